// File: rtl/fft_cu_param_if.sv
// Control/address bundle between the FFT control unit and its RAM/ROM datapath.
interface fft_cu_param_if #(
   parameter int P_ADDR_W    = 16,
   parameter int P_WC_ADDR_W = 12
);
   logic [4:0]             i_n_cfg;
   logic                   i_n_cfg_valid;
   logic                   i_data_in_valid;
   logic                   i_stall;
   logic                   i_store_end;
   logic                   i_cal_end;
   logic                   i_output_end;
   logic [4:0]             o_current_n_cfg;
   logic                   o_cfg_err;
   logic [1:0]             o_ram1_ctrl;
   logic [1:0]             o_ram2_ctrl;
   logic                   o_store_valid;
   logic [P_ADDR_W-1:0]    o_store_addr;
   logic                   o_di_valid;
   logic [P_ADDR_W-1:0]    o_di_1_addr;
   logic [P_ADDR_W-1:0]    o_di_2_addr;
   logic                   o_wc_out_valid;
   logic [P_WC_ADDR_W-1:0] o_wc_addr;
   logic [4:0]             o_stage;
   logic                   o_d_out_valid;
   logic [P_ADDR_W-1:0]    o_d_out_addr;
   logic                   o_idle_out;
   logic                   o_done;

   modport master (
      input  i_n_cfg, i_n_cfg_valid, i_data_in_valid, i_stall,
      input  i_store_end, i_cal_end, i_output_end,
      output o_current_n_cfg, o_cfg_err, o_ram1_ctrl, o_ram2_ctrl,
      output o_store_valid, o_store_addr, o_di_valid, o_di_1_addr,
      output o_di_2_addr, o_wc_out_valid, o_wc_addr, o_stage,
      output o_d_out_valid, o_d_out_addr, o_idle_out, o_done
   );

   modport slave (
      output i_n_cfg, i_n_cfg_valid, i_data_in_valid, i_stall,
      output i_store_end, i_cal_end, i_output_end,
      input  o_current_n_cfg, o_cfg_err, o_ram1_ctrl, o_ram2_ctrl,
      input  o_store_valid, o_store_addr, o_di_valid, o_di_1_addr,
      input  o_di_2_addr, o_wc_out_valid, o_wc_addr, o_stage,
      input  o_d_out_valid, o_d_out_addr, o_idle_out, o_done
   );
endinterface

// File: rtl/fft_cu_param.sv
// Radix-2 burst FFT control unit: bit-reversed store, flat-counter
// butterfly stages with drain gaps, then natural-order readout.
module fft_cu_param #(
   parameter int P_LOG2_NMAX = 13,
   parameter int P_ADDR_W    = 16,
   parameter int P_WC_ADDR_W = 12,
   parameter int P_STAGE_GAP = 4
) (
   input logic            i_clk,
   input logic            i_rst,
   fft_cu_param_if.master bus
);
   localparam int AW = P_ADDR_W;
   localparam int WW = P_WC_ADDR_W;
   localparam int GW = (P_STAGE_GAP > 1) ? $clog2(P_STAGE_GAP) : 1;
   localparam logic [GW-1:0] GAP_LAST =
      GW'((P_STAGE_GAP > 0) ? P_STAGE_GAP - 1 : 0);
   localparam logic [4:0] NMAX5  = 5'(P_LOG2_NMAX);
   localparam logic [4:0] WC_TOP = 5'(P_LOG2_NMAX - 1);
   localparam logic [AW:0] ONE   = (AW+1)'(1);

   typedef enum logic [2:0] {
      S_IDLE, S_STORE, S_WAIT_S, S_CALC,
      S_GAP, S_WAIT_C, S_OUTPUT, S_WAIT_O
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   cnt_q;
   logic [4:0]      s_q;
   logic [GW-1:0]   gap_q;
   logic            end_seen_q;

   logic            store_valid_q, store_valid_d;
   logic [AW-1:0]   store_addr_q, store_addr_d;
   logic [1:0]      ram1_q, ram1_d, ram2_q, ram2_d;
   logic            di_valid_q, di_valid_d;
   logic [AW-1:0]   di1_q, di1_d, di2_q, di2_d;
   logic [WW-1:0]   wc_q, wc_d;
   logic [4:0]      stage_q, stage_d;
   logic            dout_valid_q, dout_valid_d;
   logic [AW-1:0]   dout_q, dout_d;
   logic [4:0]      n_q, n_d;
   logic            cfg_err_q, cfg_err_d;
   logic            done_q, done_d;

   logic [AW:0]     n_pts;
   logic [AW-1:0]   last_cnt, last_b;
   logic            last_stage, cfg_ok, end_now, ended, is_wait;
   logic [AW-1:0]   rev, bf_g, bf_j, bf_a1;
   logic [WW-1:0]   bf_jw;

   assign n_pts      = ONE << n_q;
   assign last_cnt   = AW'(n_pts - ONE);
   assign last_b     = AW'((n_pts >> 1) - ONE);
   assign last_stage = (s_q == n_q - 5'd1);
   assign cfg_ok     = (bus.i_n_cfg != 5'd0) && (bus.i_n_cfg <= NMAX5);
   assign is_wait    = (state_q == S_WAIT_S) || (state_q == S_WAIT_C) ||
                       (state_q == S_WAIT_O);

   // End strobes are caught from the last active cycle of a phase onward.
   assign end_now =
      (((state_q == S_STORE)  || (state_q == S_WAIT_S)) && bus.i_store_end) ||
      (((state_q == S_CALC)   || (state_q == S_GAP) ||
        (state_q == S_WAIT_C)) && bus.i_cal_end) ||
      (((state_q == S_OUTPUT) || (state_q == S_WAIT_O)) && bus.i_output_end);
   assign ended = end_now || end_seen_q;

   always_comb begin
      rev = '0;
      for (int i = 0; i < P_LOG2_NMAX; i++)
         if (i < int'(n_q)) rev[int'(n_q) - 1 - i] = cnt_q[i];
   end

   // Upper address inserts a zero at bit s of the flat butterfly index.
   assign bf_g  = cnt_q >> s_q;
   assign bf_j  = cnt_q & ((AW'(1) << s_q) - AW'(1));
   assign bf_a1 = (bf_g << (s_q + 5'd1)) + bf_j;
   assign bf_jw = WW'(bf_j);

   always_ff @(posedge i_clk) begin
      if (i_rst) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (bus.i_n_cfg_valid && cfg_ok) state_d = S_STORE;
         S_STORE:  if (bus.i_data_in_valid && cnt_q == last_cnt)
                      state_d = S_WAIT_S;
         S_WAIT_S: if (ended) state_d = S_CALC;
         S_CALC:   if (!bus.i_stall && cnt_q == last_b) begin
                      if (last_stage)            state_d = S_WAIT_C;
                      else if (P_STAGE_GAP != 0) state_d = S_GAP;
                   end
         S_GAP:    if (gap_q == GAP_LAST) state_d = S_CALC;
         S_WAIT_C: if (ended) state_d = S_OUTPUT;
         S_OUTPUT: if (!bus.i_stall && cnt_q == last_cnt)
                      state_d = S_WAIT_O;
         S_WAIT_O: if (ended) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_q      <= '0;
         s_q        <= '0;
         gap_q      <= '0;
         end_seen_q <= 1'b0;
      end else begin
         if (state_q == S_IDLE || (is_wait && state_d != state_q))
            end_seen_q <= 1'b0;
         else if (end_now)
            end_seen_q <= 1'b1;
         case (state_q)
            S_IDLE: begin
               cnt_q <= '0;
               s_q   <= '0;
               gap_q <= '0;
            end
            S_STORE: if (bus.i_data_in_valid)
               cnt_q <= (cnt_q == last_cnt) ? '0 : cnt_q + 1'b1;
            S_CALC: if (!bus.i_stall) begin
               if (cnt_q == last_b) begin
                  cnt_q <= '0;
                  gap_q <= '0;
                  if (!last_stage) s_q <= s_q + 5'd1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_GAP: gap_q <= gap_q + 1'b1;
            S_OUTPUT: if (!bus.i_stall)
               cnt_q <= (cnt_q == last_cnt) ? '0 : cnt_q + 1'b1;
            default: ;
         endcase
      end
   end

   always_comb begin
      store_valid_d = 1'b0;
      store_addr_d  = store_addr_q;
      ram1_d        = 2'b00;
      ram2_d        = 2'b00;
      di_valid_d    = 1'b0;
      di1_d         = di1_q;
      di2_d         = di2_q;
      wc_d          = wc_q;
      stage_d       = stage_q;
      dout_valid_d  = 1'b0;
      dout_d        = dout_q;
      n_d           = n_q;
      cfg_err_d     = 1'b0;
      done_d        = 1'b0;
      unique case (state_q)
         S_IDLE: if (bus.i_n_cfg_valid) begin
            if (cfg_ok) n_d = bus.i_n_cfg;
            else        cfg_err_d = 1'b1;
         end
         S_STORE: if (bus.i_data_in_valid) begin
            store_valid_d = 1'b1;
            store_addr_d  = rev;
            ram1_d        = 2'b10;
         end
         S_CALC: if (!bus.i_stall) begin
            di_valid_d = 1'b1;
            di1_d      = bf_a1;
            di2_d      = bf_a1 + (AW'(1) << s_q);
            wc_d       = bf_jw << (WC_TOP - s_q);
            stage_d    = s_q;
            ram1_d     = s_q[0] ? 2'b10 : 2'b01;
            ram2_d     = s_q[0] ? 2'b01 : 2'b10;
         end
         S_OUTPUT: if (!bus.i_stall) begin
            dout_valid_d = 1'b1;
            dout_d       = cnt_q;
            if (n_q[0]) ram2_d = 2'b01;
            else        ram1_d = 2'b01;
         end
         S_WAIT_O: done_d = ended;
         default: ;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         store_valid_q <= 1'b0;
         store_addr_q  <= '0;
         ram1_q        <= 2'b00;
         ram2_q        <= 2'b00;
         di_valid_q    <= 1'b0;
         di1_q         <= '0;
         di2_q         <= '0;
         wc_q          <= '0;
         stage_q       <= '0;
         dout_valid_q  <= 1'b0;
         dout_q        <= '0;
         n_q           <= '0;
         cfg_err_q     <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         store_valid_q <= store_valid_d;
         store_addr_q  <= store_addr_d;
         ram1_q        <= ram1_d;
         ram2_q        <= ram2_d;
         di_valid_q    <= di_valid_d;
         di1_q         <= di1_d;
         di2_q         <= di2_d;
         wc_q          <= wc_d;
         stage_q       <= stage_d;
         dout_valid_q  <= dout_valid_d;
         dout_q        <= dout_d;
         n_q           <= n_d;
         cfg_err_q     <= cfg_err_d;
         done_q        <= done_d;
      end
   end

   assign bus.o_current_n_cfg = n_q;
   assign bus.o_cfg_err       = cfg_err_q;
   assign bus.o_ram1_ctrl     = ram1_q;
   assign bus.o_ram2_ctrl     = ram2_q;
   assign bus.o_store_valid   = store_valid_q;
   assign bus.o_store_addr    = store_addr_q;
   assign bus.o_di_valid      = di_valid_q;
   assign bus.o_di_1_addr     = di1_q;
   assign bus.o_di_2_addr     = di2_q;
   assign bus.o_wc_out_valid  = di_valid_q;
   assign bus.o_wc_addr       = wc_q;
   assign bus.o_stage         = stage_q;
   assign bus.o_d_out_valid   = dout_valid_q;
   assign bus.o_d_out_addr    = dout_q;
   assign bus.o_idle_out      = (state_q == S_IDLE);
   assign bus.o_done          = done_q;
endmodule

// File: tb/tb_fft_cu_param.sv
// Bench for fft_cu_param: directed tables and randomized transforms
// checked against a pair-enumeration reference model.
module tb_fft_cu_param;
   localparam int LMAX = 13;
   localparam int AW   = 16;
   localparam int WW   = 12;
   localparam int GAP  = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fft_cu_param_if #(.P_ADDR_W(AW), .P_WC_ADDR_W(WW)) bus ();

   fft_cu_param #(
      .P_LOG2_NMAX(LMAX), .P_ADDR_W(AW),
      .P_WC_ADDR_W(WW), .P_STAGE_GAP(GAP)
   ) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

   typedef struct { int a1; int a2; int wc; int st; } bfly_t;
   typedef struct { logic [4:0] n; logic v; logic err; } cfg_vec_t;
   typedef struct { logic vin; logic ev; int ea; } st_vec_t;

   int    passed = 0;
   int    total  = 0;
   int    q_st[$];
   int    q_out[$];
   bfly_t q_bf[$];

   function automatic void chk(string name, longint act, longint exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endfunction

   function automatic int bitrev(int k, int n);
      int r;
      int v;
      r = 0;
      v = k;
      for (int i = 0; i < n; i++) begin
         r = r * 2 + (v % 2);
         v = v / 2;
      end
      return r;
   endfunction

   // Butterflies listed group by group, pair by pair, from FFT structure.
   function automatic void build_model(int n);
      int    np;
      int    span;
      bfly_t b;
      np = 1 << n;
      q_st.delete();
      q_bf.delete();
      q_out.delete();
      for (int k = 0; k < np; k++) q_st.push_back(bitrev(k, n));
      for (int s = 0; s < n; s++) begin
         span = 1 << s;
         for (int base = 0; base < np; base += 2 * span)
            for (int j = 0; j < span; j++) begin
               b.a1 = base + j;
               b.a2 = base + j + span;
               b.wc = j * ((1 << (LMAX - 1)) / span);
               b.st = s;
               q_bf.push_back(b);
            end
      end
      for (int k = 0; k < np; k++) q_out.push_back(k);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      bus.i_n_cfg         = 5'd0;
      bus.i_n_cfg_valid   = 1'b0;
      bus.i_data_in_valid = 1'b0;
      bus.i_stall         = 1'b0;
      bus.i_store_end     = 1'b0;
      bus.i_cal_end       = 1'b0;
      bus.i_output_end    = 1'b0;
   endtask

   task automatic check_reset(string tag);
      chk({tag, "_store_valid"}, bus.o_store_valid, 0);
      chk({tag, "_store_addr"}, bus.o_store_addr, 0);
      chk({tag, "_ctrl"}, {bus.o_ram1_ctrl, bus.o_ram2_ctrl}, 0);
      chk({tag, "_di_valid"}, bus.o_di_valid, 0);
      chk({tag, "_di_addrs"}, {bus.o_di_1_addr, bus.o_di_2_addr}, 0);
      chk({tag, "_wc"}, {bus.o_wc_out_valid, bus.o_wc_addr}, 0);
      chk({tag, "_stage"}, bus.o_stage, 0);
      chk({tag, "_dout"}, {bus.o_d_out_valid, bus.o_d_out_addr}, 0);
      chk({tag, "_ncfg"}, bus.o_current_n_cfg, 0);
      chk({tag, "_err_done"}, {bus.o_cfg_err, bus.o_done}, 0);
      chk({tag, "_idle"}, bus.o_idle_out, 1);
   endtask

   task automatic run_transform(input int n, input int vmode,
                                input int sprob, input bit early,
                                input int st_stage, input int st_b);
      int    np, nbf, sent, st_seen, bf_seen, out_seen;
      int    phase, dly, hold, zrun, lstage, bidx, ev;
      bit    tog, hold_now;
      bfly_t eb;
      np  = 1 << n;
      nbf = (np / 2) * n;
      build_model(n);
      bus.i_n_cfg       = 5'(n);
      bus.i_n_cfg_valid = 1'b1;
      step();
      bus.i_n_cfg_valid = 1'b0;
      chk("cfg_latch", bus.o_current_n_cfg, n);
      sent = 0; st_seen = 0; bf_seen = 0; out_seen = 0;
      phase = 0; hold = 0; zrun = 0; lstage = -1; bidx = 0; tog = 1'b1;
      dly = $urandom_range(2, 0);
      for (int cyc = 0; cyc < 20000 && phase < 3; cyc++) begin
         bus.i_data_in_valid = 1'b0;
         bus.i_store_end     = 1'b0;
         bus.i_cal_end       = 1'b0;
         bus.i_output_end    = 1'b0;
         if (phase == 0 && sent < np) begin
            bus.i_data_in_valid = (vmode == 0) || (vmode == 1 && tog) ||
                                  (vmode == 2 && $urandom_range(1, 0) == 1);
            tog = !tog;
            if (bus.i_data_in_valid) begin
               sent++;
               if (sent == np && early) begin
                  bus.i_store_end = 1'b1;
                  phase = 1;
               end
            end
         end else if (phase == 0 && st_seen == np) begin
            if (dly == 0) begin
               bus.i_store_end = 1'b1;
               phase = 1;
               dly = $urandom_range(2, 0);
            end else dly--;
         end else if (phase == 1 && bf_seen == nbf) begin
            if (dly == 0) begin
               bus.i_cal_end = 1'b1;
               phase = 2;
               dly = $urandom_range(2, 0);
            end else dly--;
         end else if (phase == 2 && out_seen == np) begin
            if (dly == 0) begin
               bus.i_output_end = 1'b1;
               phase = 3;
            end else dly--;
         end
         hold_now = (hold > 0);
         if (hold_now) begin
            bus.i_stall = 1'b1;
            hold--;
         end else begin
            bus.i_stall = (sprob > 0) && ($urandom_range(99, 0) < sprob);
         end
         step();
         if (hold_now)
            chk("stall_valids_low", {bus.o_di_valid, bus.o_wc_out_valid}, 0);
         if (bus.o_store_valid) begin
            ev = -1;
            if (q_st.size() > 0) ev = q_st.pop_front();
            chk("store_addr", bus.o_store_addr, ev);
            chk("store_ctrl", {bus.o_ram1_ctrl, bus.o_ram2_ctrl}, 4'b1000);
            st_seen++;
         end
         if (bus.o_di_valid) begin
            eb = '{-1, -1, -1, -1};
            if (q_bf.size() > 0) eb = q_bf.pop_front();
            chk("di_1_addr", bus.o_di_1_addr, eb.a1);
            chk("di_2_addr", bus.o_di_2_addr, eb.a2);
            chk("wc_addr", bus.o_wc_addr, eb.wc);
            chk("stage", bus.o_stage, eb.st);
            chk("wc_valid", bus.o_wc_out_valid, 1);
            chk("calc_ctrl", {bus.o_ram1_ctrl, bus.o_ram2_ctrl},
                (eb.st % 2 == 0) ? 4'b0110 : 4'b1001);
            if (lstage >= 0 && int'(bus.o_stage) != lstage) begin
               if (sprob == 0) chk("stage_gap", zrun, GAP);
               bidx = 0;
            end
            lstage = bus.o_stage;
            zrun = 0;
            bf_seen++;
            if (lstage == st_stage && bidx == st_b - 1) hold = 3;
            bidx++;
         end else if (bf_seen > 0 && bf_seen < nbf) begin
            zrun++;
         end
         if (bus.o_d_out_valid) begin
            ev = -1;
            if (q_out.size() > 0) ev = q_out.pop_front();
            chk("d_out_addr", bus.o_d_out_addr, ev);
            chk("out_ctrl", {bus.o_ram1_ctrl, bus.o_ram2_ctrl},
                (n % 2 == 1) ? 4'b0001 : 4'b0100);
            out_seen++;
         end
         if (!bus.o_store_valid && !bus.o_di_valid && !bus.o_d_out_valid)
            chk("idle_ctrl", {bus.o_ram1_ctrl, bus.o_ram2_ctrl}, 0);
      end
      bus.i_output_end = 1'b0;
      bus.i_stall      = 1'b0;
      chk("run_complete", phase, 3);
      chk("done_pulse", bus.o_done, 1);
      chk("idle_after_done", bus.o_idle_out, 1);
      chk("model_drained", q_st.size() + q_bf.size() + q_out.size(), 0);
      step();
      chk("done_one_cycle", bus.o_done, 0);
   endtask

   cfg_vec_t cv[6];
   st_vec_t  sv[16];
   int       lit[8];
   bit       seen;

   initial begin
      cv[0] = '{5'd14, 1'b1, 1'b1};
      cv[1] = '{5'd0,  1'b1, 1'b1};
      cv[2] = '{5'd31, 1'b1, 1'b1};
      cv[3] = '{5'd20, 1'b1, 1'b1};
      cv[4] = '{5'd5,  1'b0, 1'b0};
      cv[5] = '{5'd14, 1'b0, 1'b0};
      lit = '{0, 4, 2, 6, 1, 5, 3, 7};
      for (int i = 0; i < 16; i++)
         sv[i] = '{(i % 2 == 0), (i % 2 == 0), lit[i / 2]};

      clear_in();
      rst = 1'b1;
      step();
      step();
      check_reset("reset");
      rst = 1'b0;
      step();
      check_reset("post_reset");

      foreach (cv[i]) begin
         bus.i_n_cfg       = cv[i].n;
         bus.i_n_cfg_valid = cv[i].v;
         step();
         chk("cfg_err", bus.o_cfg_err, cv[i].err);
         chk("cfg_stay_idle", bus.o_idle_out, 1);
         chk("cfg_keep_n", bus.o_current_n_cfg, 0);
         bus.i_n_cfg_valid = 1'b0;
         step();
         chk("cfg_err_pulse", bus.o_cfg_err, 0);
      end

      // Gapped store, valid on alternate cycles.
      bus.i_n_cfg       = 5'd3;
      bus.i_n_cfg_valid = 1'b1;
      step();
      bus.i_n_cfg_valid = 1'b0;
      chk("tbl_ncfg", bus.o_current_n_cfg, 3);
      chk("tbl_left_idle", bus.o_idle_out, 0);
      foreach (sv[i]) begin
         bus.i_data_in_valid = sv[i].vin;
         step();
         chk("tbl_store_valid", bus.o_store_valid, sv[i].ev);
         chk("tbl_ram1", bus.o_ram1_ctrl, sv[i].ev ? 2 : 0);
         if (sv[i].ev) chk("tbl_store_addr", bus.o_store_addr, sv[i].ea);
      end
      bus.i_data_in_valid = 1'b0;
      chk("tbl_wait_s", bus.o_idle_out, 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();

      run_transform(3, 0, 0, 1'b0, 1, 2);
      run_transform(3, 1, 0, 1'b0, -1, 0);
      run_transform(4, 0, 0, 1'b1, -1, 0);
      run_transform(1, 0, 0, 1'b0, -1, 0);

      // Reset while butterflies are being issued.
      bus.i_n_cfg       = 5'd2;
      bus.i_n_cfg_valid = 1'b1;
      step();
      bus.i_n_cfg_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.i_data_in_valid = 1'b1;
         bus.i_store_end     = (i == 3);
         step();
      end
      bus.i_data_in_valid = 1'b0;
      bus.i_store_end     = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         step();
         seen = bus.o_di_valid;
      end
      chk("mid_calc_reached", seen, 1);
      rst = 1'b1;
      step();
      check_reset("mid_calc_rst");
      rst = 1'b0;
      step();
      chk("mid_calc_idle", bus.o_idle_out, 1);

      for (int r = 0; r < 10; r++)
         run_transform($urandom_range(8, 1), 2, 30,
                       1'($urandom_range(1, 0)), -1, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
